hs_ram_arbiter: RTL and testbench
=================================

# hs_ram_arbiter

Shares the game CPU's single-port work RAM between the CPU and the hiscore save/restore engine. When the hiscore engine signals intent to read or write, the block raises a CPU pause request and waits for the CPU bus to go quiet. It then hands the RAM port to the hiscore engine and returns it to the CPU cleanly afterwards. It sits in the core top level, between the CPU bus decode, the work RAM and the hiscore module's ram_* ports.

## Interface

Parameters:

- AW, 12, RAM address width
- DW, 8, RAM data width
- SETTLE, 4, consecutive cycles with no cpu_cen required before the grant (range 1..15)

Ports:

- clk_49m  in  1  system clock, the only clock
- reset  in  1  asynchronous, active-low reset
- cpu_cen  in  1  CPU bus-cycle strobe; a CPU access happens only on cycles where this is 1
- cpu_sel  in  1  work-RAM chip select from CPU address decode
- cpu_we  in  1  CPU write
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  CPU read data, held in a register
- hs_access_read  in  1  hiscore read intent
- hs_access_write  in  1  hiscore write intent
- hs_we  in  1  hiscore write strobe
- hs_addr  in  AW  hiscore address
- hs_din  in  DW  hiscore write data
- hs_dout  out  DW  hiscore read data, held in a register
- hs_grant  out  1  hiscore owns the RAM
- pause_req  out  1  pause request to the pause system, active-high
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DW  RAM read data; 1-cycle synchronous read latency

## Operation

- State machine states: IDLE, DRAIN, GRANT, RELEASE. Reset forces IDLE.
- Intent is defined as `hs_access_read | hs_access_write`.
- Ownership:
  - The owner select is a registered signal, equal to 1 only in GRANT.
  - The ram_* outputs are a combinational mux selected by the owner select.
- CPU-owned (IDLE, DRAIN, RELEASE):
  - ram_addr = cpu_addr, ram_din = cpu_din.
  - ram_we = cpu_sel & cpu_we & cpu_cen.
  - In RELEASE, ram_we is forced to 0.
- Hiscore-owned (GRANT):
  - ram_addr = hs_addr, ram_din = hs_din, ram_we = hs_we.
- IDLE:
  - pause_req = 0, hs_grant = 0.
  - Intent = 1 → DRAIN; load the quiet counter with SETTLE.
- DRAIN:
  - pause_req = 1.
  - Any cycle with cpu_cen = 1 reloads the counter to SETTLE. Otherwise the counter decrements.
  - Counter reaches 0 while intent = 1 → GRANT.
  - Intent drops at any point → RELEASE (abort).
- GRANT:
  - pause_req = 1, hs_grant = 1.
  - Stays in GRANT while intent = 1.
  - Intent = 0 → RELEASE.
  - cpu_cen arriving during GRANT is ignored; the RAM is not written by the CPU.
- RELEASE:
  - pause_req = 0, hs_grant = 0.
  - Lasts exactly 1 cycle, then → IDLE.
  - An intent present in RELEASE is serviced from IDLE on the next cycle.
- Read data:
  - cpu_dout captures ram_dout on the cycle after a CPU-owned cycle in which cpu_cen & cpu_sel & ~cpu_we was 1.
  - hs_dout captures ram_dout on every cycle that follows a GRANT cycle.
  - cpu_dout is frozen throughout DRAIN and GRANT, so the CPU resumes with its last read value.
- Simultaneous events:
  - Intent rising on a cycle with cpu_cen = 1 in IDLE: that CPU access completes on the CPU mux, and DRAIN begins next cycle with counter = SETTLE.
  - hs_we asserted while not in GRANT has no effect on the RAM.

## Timing

- Reset values: pause_req = 0, hs_grant = 0, cpu_dout = 0, hs_dout = 0, state = IDLE, counter = 0.
  - ram_we = 0 unless a CPU write strobe is present.
- Intent rise at cycle N (in IDLE):
  - pause_req = 1 from N+1.
  - With no cpu_cen, hs_grant = 1 from N+1+SETTLE.
- Intent fall at cycle M (in GRANT):
  - hs_grant = 0 and pause_req = 0 from M+1 (RELEASE).
  - CPU access to the RAM resumes from M+2.
- RAM read latency: data appears on hs_dout or cpu_dout 2 cycles after the address is presented.
- Reset asserted mid-DRAIN or mid-GRANT: all outputs return to their reset values immediately (asynchronous); no RAM write occurs after reset assertion.

## Test plan

- Reset: assert reset with intent = 1 → pause_req = 0, hs_grant = 0, cpu_dout = 0x00, state IDLE.
- CPU passthrough: write 0xA5 to addr 0x123 with cpu_cen pulse, then read it back → ram_we = 1 for exactly 1 cycle; cpu_dout = 0xA5 two cycles after the read.
- Grant latency: SETTLE = 4, raise hs_access_read at N with cpu_cen = 0 → pause_req = 1 at N+1, hs_grant = 1 at N+5; hs_addr = 0x123 → hs_dout = 0xA5 two cycles later.
- Drain restart: cpu_cen pulses at N+2 and N+4 during DRAIN → hs_grant does not rise until 4 quiet cycles after N+4 (at N+9).
- Hiscore write and release: in GRANT write 0x3C to 0x010, drop intent at M → hs_grant = 0 at M+1; CPU read of 0x010 issued at M+2 returns 0x3C; cpu_dout is unchanged throughout GRANT.
- Abort and reset: drop intent during DRAIN → RELEASE then IDLE with hs_grant never 1; in a separate run, assert reset mid-GRANT with hs_we = 1 → ram_we = 0 and hs_grant = 0 immediately.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the game CPU and the hiscore save/restore engine.
// Pauses the CPU, waits for a quiet bus, then lends the RAM port to the hiscore engine.
module hs_ram_arbiter #(
  parameter int unsigned AW     = 12,
  parameter int unsigned DW     = 8,
  parameter int unsigned SETTLE = 4
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          cpu_cen,
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  input  logic          hs_access_read,
  input  logic          hs_access_write,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_din,
  output logic [DW-1:0] hs_dout,
  output logic          hs_grant,
  output logic          pause_req,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state;
  logic [3:0] quiet_cnt;
  logic       hs_owner;
  logic       cpu_rd_pend;
  logic       hs_rd_pend;
  logic       intent;

  assign intent = hs_access_read | hs_access_write;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      quiet_cnt <= '0;
      pause_req <= 1'b0;
      hs_grant  <= 1'b0;
      hs_owner  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (intent) begin
            state     <= DRAIN;
            quiet_cnt <= SETTLE_CNT;
            pause_req <= 1'b1;
          end
        end
        DRAIN: begin
          // Grant on the cycle the count would hit zero, so the grant lands SETTLE quiet cycles after DRAIN entry.
          if (!intent) begin
            state     <= RELEASE;
            pause_req <= 1'b0;
          end else if (cpu_cen) begin
            quiet_cnt <= SETTLE_CNT;
          end else if (quiet_cnt <= 4'd1) begin
            state     <= GRANT;
            quiet_cnt <= '0;
            hs_grant  <= 1'b1;
            hs_owner  <= 1'b1;
          end else begin
            quiet_cnt <= quiet_cnt - 4'd1;
          end
        end
        GRANT: begin
          if (!intent) begin
            state     <= RELEASE;
            pause_req <= 1'b0;
            hs_grant  <= 1'b0;
            hs_owner  <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          pause_req <= 1'b0;
          hs_grant  <= 1'b0;
          hs_owner  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = cpu_sel & cpu_we & cpu_cen & (state != RELEASE);
    if (hs_owner) begin
      ram_addr = hs_addr;
      ram_din  = hs_din;
      ram_we   = hs_we;
    end
  end

  // CPU reads are only tracked while unpaused so cpu_dout holds across DRAIN and GRANT.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      cpu_rd_pend <= 1'b0;
      hs_rd_pend  <= 1'b0;
      cpu_dout    <= '0;
      hs_dout     <= '0;
    end else begin
      cpu_rd_pend <= (state == IDLE) & cpu_cen & cpu_sel & ~cpu_we;
      hs_rd_pend  <= hs_owner;
      if (cpu_rd_pend) cpu_dout <= ram_dout;
      if (hs_rd_pend)  hs_dout  <= ram_dout;
    end
  end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a behavioural synchronous work RAM attached.
module tb_hs_ram_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk_49m = 1'b0;
  logic          reset;
  logic          cpu_cen, cpu_sel, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          hs_access_read, hs_access_write, hs_we;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_din;
  logic [DW-1:0] hs_dout;
  logic          hs_grant, pause_req;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int passed = 0;
  int total  = 0;

  hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(4)) dut (
    .clk_49m(clk_49m), .reset(reset),
    .cpu_cen(cpu_cen), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .hs_access_read(hs_access_read), .hs_access_write(hs_access_write),
    .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din), .hs_dout(hs_dout),
    .hs_grant(hs_grant), .pause_req(pause_req),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_49m = ~clk_49m;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  end

  always @(posedge clk_49m) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_cen = 1'b0; cpu_sel = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cpu_idle();
    cpu_addr = '0; cpu_din = '0;
    hs_access_read = 1'b1; hs_access_write = 1'b0; hs_we = 1'b0;
    hs_addr = '0; hs_din = '0;

    // Reset held with intent present
    tick(); tick();
    check("rst_pause",    32'(pause_req), 32'h0);
    check("rst_grant",    32'(hs_grant),  32'h0);
    check("rst_cpu_dout", 32'(cpu_dout),  32'h00);
    check("rst_hs_dout",  32'(hs_dout),   32'h00);
    check("rst_ram_we",   32'(ram_we),    32'h0);
    hs_access_read = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    check("rst_idle_pause", 32'(pause_req), 32'h0);

    // CPU write 0xA5 -> 0x123, then read back
    cpu_cen = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'hA5;
    #1;
    check("cpu_wr_we",   32'(ram_we),   32'h1);
    check("cpu_wr_addr", 32'(ram_addr), 32'h123);
    check("cpu_wr_din",  32'(ram_din),  32'hA5);
    tick();
    cpu_cen = 1'b0;
    #1;
    check("cpu_wr_we_1cyc", 32'(ram_we), 32'h0);
    tick();
    cpu_cen = 1'b1; cpu_we = 1'b0;          // read at cycle R
    tick();
    cpu_idle();                             // R+1
    check("cpu_rd_r1", 32'(cpu_dout), 32'h00);
    tick();                                 // R+2
    check("cpu_rd_r2", 32'(cpu_dout), 32'hA5);

    // Grant latency with a quiet bus
    hs_access_read = 1'b1; hs_addr = 12'h123;   // cycle N
    #1;
    check("gl_pause_n", 32'(pause_req), 32'h0);
    tick();                                     // N+1
    check("gl_pause_n1", 32'(pause_req), 32'h1);
    check("gl_grant_n1", 32'(hs_grant),  32'h0);
    tick(); tick(); tick();                     // N+4
    check("gl_grant_n4", 32'(hs_grant), 32'h0);
    tick();                                     // N+5
    check("gl_grant_n5", 32'(hs_grant), 32'h1);
    check("gl_ram_addr", 32'(ram_addr), 32'h123);
    tick(); tick();                             // N+7
    check("gl_hs_dout", 32'(hs_dout), 32'hA5);
    hs_access_read = 1'b0;                      // M
    tick();                                     // M+1
    check("gl_rel_grant", 32'(hs_grant),  32'h0);
    check("gl_rel_pause", 32'(pause_req), 32'h0);
    tick();

    // Drain restart from CPU strobes at N+2 and N+4
    hs_access_read = 1'b1;                      // N
    tick();                                     // N+1
    tick(); cpu_cen = 1'b1;                     // N+2
    tick(); cpu_cen = 1'b0;                     // N+3
    tick(); cpu_cen = 1'b1;                     // N+4
    tick(); cpu_cen = 1'b0;                     // N+5
    check("dr_pause", 32'(pause_req), 32'h1);
    tick(); tick(); tick();                     // N+8
    check("dr_grant_n8", 32'(hs_grant), 32'h0);
    tick();                                     // N+9
    check("dr_grant_n9", 32'(hs_grant), 32'h1);

    // Hiscore write, CPU blocked, release
    hs_access_write = 1'b1; hs_access_read = 1'b0;
    hs_addr = 12'h010; hs_din = 8'h3C; hs_we = 1'b1;
    #1;
    check("hw_we",   32'(ram_we),   32'h1);
    check("hw_addr", 32'(ram_addr), 32'h010);
    check("hw_din",  32'(ram_din),  32'h3C);
    tick();
    hs_we = 1'b0;
    cpu_cen = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_din = 8'hFF;
    #1;
    check("hw_cpu_wr_blocked", 32'(ram_we), 32'h0);
    tick();
    cpu_we = 1'b0;                              // CPU read attempt during GRANT
    tick();
    cpu_idle();
    check("hw_cpu_dout_frozen1", 32'(cpu_dout), 32'hA5);
    tick();
    check("hw_cpu_dout_frozen2", 32'(cpu_dout), 32'hA5);
    hs_access_write = 1'b0;                     // M
    #1;
    check("hw_grant_m", 32'(hs_grant), 32'h1);
    tick();                                     // M+1 RELEASE
    check("hw_grant_m1", 32'(hs_grant),  32'h0);
    check("hw_pause_m1", 32'(pause_req), 32'h0);
    cpu_cen = 1'b1; cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_din = 8'hFF;
    #1;
    check("hw_release_we", 32'(ram_we), 32'h0);
    tick();                                     // M+2 CPU read
    cpu_we = 1'b0;
    tick();                                     // M+3
    cpu_idle();
    tick();                                     // M+4
    check("hw_cpu_rd", 32'(cpu_dout), 32'h3C);

    // Abort during DRAIN
    hs_access_read = 1'b1;                      // N
    tick();                                     // N+1
    check("ab_pause_n1", 32'(pause_req), 32'h1);
    tick();                                     // N+2
    hs_access_read = 1'b0;
    check("ab_grant_n2", 32'(hs_grant), 32'h0);
    tick();                                     // N+3 RELEASE
    check("ab_pause_n3", 32'(pause_req), 32'h0);
    check("ab_grant_n3", 32'(hs_grant),  32'h0);
    tick(); tick(); tick(); tick(); tick();
    check("ab_grant_late", 32'(hs_grant), 32'h0);
    check("ab_pause_late", 32'(pause_req), 32'h0);

    // Asynchronous reset mid-GRANT with hs_we asserted
    hs_access_read = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("ar_grant", 32'(hs_grant), 32'h1);
    hs_we = 1'b1; hs_addr = 12'h055; hs_din = 8'h77;
    #1;
    check("ar_we_before", 32'(ram_we), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("ar_we_after",    32'(ram_we),    32'h0);
    check("ar_grant_after", 32'(hs_grant),  32'h0);
    check("ar_pause_after", 32'(pause_req), 32'h0);
    check("ar_cpu_dout",    32'(cpu_dout),  32'h00);
    check("ar_hs_dout",     32'(hs_dout),   32'h00);
    hs_we = 1'b0; hs_access_read = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
